spart_rx: RTL and testbench
===========================

# spart_rx

Receive half of the SPART. It consumes the 16x-oversample `enable` tick produced by `baud_rate_generator` and the asynchronous `rxd` line. It deserialises 8N1 frames (LSB first) into a holding register. It then presents the byte, `rda` and error flags to the SPART bus-interface logic, which returns a one-cycle read strobe.

## Interface
Parameters:
- DATA_BITS, 8, payload bits per frame
- OVERSAMPLE, 16, `enable` ticks per bit period

Ports:
- clk  input  1  system clock; single clock domain
- rst  input  1  synchronous, active-high reset
- enable  input  1  one-`clk`-wide oversample tick from `baud_rate_generator`, 16 per bit period
- rxd  input  1  serial receive line; asynchronous; idles high
- rd_strobe  input  1  one-cycle pulse; bus logic has consumed `rx_data`
- rx_data  output  8  last completed byte
- rda  output  1  receive data available
- framing_err  output  1  stop bit of the last frame sampled low
- overrun  output  1  byte completed while `rda` was still set

## Operation
- `rxd` passes through a 2-flop synchroniser; both flops reset to 1. A falling-edge detect on the synchronised line gives `start_det`.
- State IDLE: wait for `start_det`. On detect, clear the tick counter and go to START.
- State START:
  - Count 8 `enable` ticks (half a bit period).
  - If the synchronised `rxd` is 0 on the 8th tick, clear the tick counter and the bit index, then go to DATA.
  - If it is 1, it was a false start: return to IDLE with no flags changed.
- State DATA:
  - Every 16th tick, sample `rxd` into the shift register (LSB first) and increment the 3-bit bit index.
  - After the sample with index 7, go to STOP.
- State STOP: on the 16th tick, sample the stop bit, then:
  - Load `rx_data` from the shift register and set `rda`.
  - Set `framing_err` to the inverse of the stop sample.
  - Set `overrun` if `rda` was already 1 and `rd_strobe` is not asserted this cycle.
  - Return to IDLE.
- A new byte always overwrites `rx_data`. Error flags are sticky until read.
- `rd_strobe` clears `rda`, `framing_err` and `overrun` on the next edge.
- `rd_strobe` in the same cycle as frame completion: completion wins.
  - `rda` = 1 and `rx_data` = new byte.
  - `overrun` is not set.
  - `framing_err` reflects the new frame.
- The tick counter (4-bit) advances only on `enable`. `clk` cycles without `enable` hold all state.
- `enable` held low: the FSM stalls in its current state indefinitely.

## Timing
- Reset values:
  - FSM in IDLE; counters 0; shift register 0.
  - `rx_data` = 0x00, `rda` = 0, `framing_err` = 0, `overrun` = 0.
- Synchroniser latency is 2 `clk` cycles.
- Start detection is quantised to one `clk`; all sampling points are quantised to `enable` ticks.
- Stop-bit sample falls 8 + 9×16 = 152 ticks after `start_det`.
- `rda`, `rx_data` and the error flags update on the `clk` edge of the stop-sample tick, visible the next cycle.
- `rst` mid-frame: back to IDLE on the next edge, all outputs at reset values. A partially received frame is discarded.
- No break detection: a line held low gives a frame of 0x00 with `framing_err` = 1. The FSM then waits in IDLE for the next falling edge, so a constant-low line produces no further frames.
- Back-to-back frames are supported: a start edge may be detected the cycle after STOP exits.

## Structure
- Package `spart_pkg`:
  - `rx_state_t` enum (IDLE, START, DATA, STOP)
  - `OVERSAMPLE` = 16, `HALF_BIT` = 8, `DATA_BITS` = 8
  - shared with the future `spart_tx`
- Sub-module `spart_sync`: 2-flop synchroniser plus registered falling-edge detect. Reused for any other asynchronous input.
- Top: `spart_rx` (FSM, tick counter, bit index, shift register, output registers), instantiated in `spart` beside `baud_rate_generator`.

## Test plan
All tests use `enable` every 4 `clk` (bit period 64 clk).
- Send 0xA5 with a valid stop bit -> `rda` rises ~608 clk after the start edge; `rx_data` = 0xA5; `framing_err` = 0; `overrun` = 0.
- Low glitch on `rxd` for 3 ticks -> FSM returns to IDLE; `rda` stays 0; later 0x5A received correctly.
- Send 0x3C with the stop bit driven 0 -> `rda` = 1, `rx_data` = 0x3C, `framing_err` = 1; `rd_strobe` -> all three flags 0 next cycle.
- Send 0x11 then 0x22 without a read -> `rx_data` = 0x22, `rda` = 1, `overrun` = 1. Repeat with `rd_strobe` on the exact completion cycle of 0x22 -> `overrun` = 0, `rda` = 1.
- Assert `rst` during data bit 4 of 0xFF -> next cycle all outputs at reset values; the subsequent frame 0x81 is received correctly.
- Hold `enable` low for 1000 clk mid-frame, then resume -> frame completes with the correct byte; no spurious `rda`.

Source files
------------

// File: rtl/spart_pkg.sv
// Shared SPART definitions: oversampling constants and the receive FSM state type.
package spart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int HALF_BIT   = OVERSAMPLE / 2;
  localparam int DATA_BITS  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/spart_sync.sv
// Two-flop synchroniser for an asynchronous input, plus falling-edge detect on the
// synchronised level. Flops reset to 1 so an idle-high line gives no edge out of reset.
module spart_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out,
  output logic fall
);

  logic meta;
  logic sync_q;
  logic sync_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the chain into one flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta   <= 1'b1;
      sync_q <= 1'b1;
      sync_d <= 1'b1;
    end else begin
      meta   <= async_in;
      sync_q <= meta;
      sync_d <= sync_q;
    end
  end

  assign sync_out = sync_q;
  assign fall     = sync_d & ~sync_q;

endmodule

// File: rtl/spart_rx.sv
// SPART receiver: deserialises 8N1 frames using a 16x oversample tick and presents
// the byte with rda / framing_err / overrun to the bus-interface logic.
module spart_rx #(
  parameter int DATA_BITS  = spart_pkg::DATA_BITS,
  parameter int OVERSAMPLE = spart_pkg::OVERSAMPLE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 rxd,
  input  logic                 rd_strobe,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rda,
  output logic                 framing_err,
  output logic                 overrun
);

  import spart_pkg::*;

  localparam int CW   = $clog2(OVERSAMPLE);
  localparam int BW   = $clog2(DATA_BITS);
  localparam int HALF = OVERSAMPLE / 2;

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_START = START;
  localparam logic [1:0] S_DATA  = DATA;
  localparam logic [1:0] S_STOP  = STOP;

  logic [1:0]           state;
  logic [CW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 rx_s;
  logic                 start_det;
  logic                 tick_half;
  logic                 tick_last;
  logic                 frame_done;

  spart_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (rxd),
    .sync_out (rx_s),
    .fall     (start_det)
  );

  assign tick_half  = enable && (tick_cnt == CW'(HALF - 1));
  assign tick_last  = enable && (tick_cnt == CW'(OVERSAMPLE - 1));
  assign frame_done = (state == S_STOP) && tick_last;

  // NOTE: the shift register is reset along with the control state so that
  // rx_data can never present bits left over from before reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      tick_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
    end else begin
      if (enable && state != S_IDLE) tick_cnt <= tick_cnt + 1'b1;
      case (state)
        S_IDLE: begin
          if (start_det) begin
            tick_cnt <= '0;
            state    <= S_START;
          end
        end
        S_START: begin
          // Mid-start-bit check: a line back high means a glitch, not a frame.
          if (tick_half) begin
            tick_cnt <= '0;
            bit_idx  <= '0;
            state    <= rx_s ? S_IDLE : S_DATA;
          end
        end
        S_DATA: begin
          if (tick_last) begin
            shift   <= {rx_s, shift[DATA_BITS-1:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == BW'(DATA_BITS - 1)) state <= S_STOP;
          end
        end
        S_STOP: begin
          if (tick_last) state <= S_IDLE;
        end
        // NOTE: a default arm keeps the case complete; in combinational blocks the
        // same habit (plus defaults up front) is what prevents inferred latches.
        default: state <= S_IDLE;
      endcase
    end
  end

  // Completion outranks a simultaneous read: the new byte stays flagged as unread.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data     <= '0;
      rda         <= 1'b0;
      framing_err <= 1'b0;
      overrun     <= 1'b0;
    end else if (frame_done) begin
      rx_data     <= shift;
      rda         <= 1'b1;
      framing_err <= ~rx_s;
      overrun     <= rd_strobe ? 1'b0 : (overrun | rda);
    end else if (rd_strobe) begin
      rda         <= 1'b0;
      framing_err <= 1'b0;
      overrun     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spart_rx.sv
// Self-checking bench for spart_rx: tick-timed serial transmitter, frame-level
// reference model, directed cases plus randomised frames.
module tb_spart_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       rxd = 1'b1;
  logic       rd_strobe = 1'b0;
  logic [7:0] rx_data;
  logic       rda;
  logic       framing_err;
  logic       overrun;

  spart_rx dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .rxd         (rxd),
    .rd_strobe   (rd_strobe),
    .rx_data     (rx_data),
    .rda         (rda),
    .framing_err (framing_err),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic val;
    int   ticks;
    bit   first;
    bit   strobe;
  } seg_t;

  seg_t tx_q[$];
  seg_t seg;
  int   line_ticks   = 0;
  int   issued       = 0;
  int   cyc          = 0;
  int   phase        = 0;
  bit   en_run       = 1'b1;
  bit   req_read     = 1'b0;
  int   strobe_at    = -1;
  int   start_cyc    = 0;
  int   rda_rise_cyc = -1;
  logic rda_prev     = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: frame-level state of the receive holding register and flags.
  logic [7:0] m_data = 8'h00;
  bit         m_rda  = 1'b0;
  bit         m_fe   = 1'b0;
  bit         m_ov   = 1'b0;

  // Single stimulus process on the falling edge: enable tick every 4 clk, serial
  // line segments timed in ticks, one-cycle read strobes.
  always @(negedge clk) begin
    cyc++;
    if (rda && !rda_prev && rda_rise_cyc < 0) rda_rise_cyc = cyc;
    rda_prev  = rda;
    rd_strobe = 1'b0;
    if (req_read) begin
      rd_strobe = 1'b1;
      req_read  = 1'b0;
    end
    enable = 1'b0;
    if (en_run) begin
      phase = (phase + 1) % 4;
      if (phase == 0) begin
        enable = 1'b1;
        issued++;
        if (issued == strobe_at) rd_strobe = 1'b1;
        if (line_ticks > 0) line_ticks--;
        if (line_ticks == 0 && tx_q.size() > 0) begin
          seg        = tx_q.pop_front();
          rxd        = seg.val;
          line_ticks = seg.ticks;
          if (seg.first) begin
            start_cyc = cyc;
            strobe_at = seg.strobe ? issued + 152 : -1;
          end
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic check_all(input string tag);
    check({tag, "_data"}, 32'(rx_data), 32'(m_data));
    check({tag, "_rda"}, 32'(rda), 32'(m_rda));
    check({tag, "_ferr"}, 32'(framing_err), 32'(m_fe));
    check({tag, "_ovr"}, 32'(overrun), 32'(m_ov));
  endtask

  task automatic m_frame(input logic [7:0] d, input bit stop, input bit rd_same);
    m_ov   = rd_same ? 1'b0 : (m_ov | m_rda);
    m_rda  = 1'b1;
    m_data = d;
    m_fe   = !stop;
  endtask

  task automatic m_clear(input bit full);
    m_rda = 1'b0;
    m_fe  = 1'b0;
    m_ov  = 1'b0;
    if (full) m_data = 8'h00;
  endtask

  task automatic push_frame(input logic [7:0] d, input bit stop, input bit strobe, input int gap);
    tx_q.push_back('{1'b0, 16, 1'b1, strobe});
    for (int i = 0; i < 8; i++) tx_q.push_back('{d[i], 16, 1'b0, 1'b0});
    tx_q.push_back('{stop, 16, 1'b0, 1'b0});
    if (gap > 0) tx_q.push_back('{1'b1, gap, 1'b0, 1'b0});
  endtask

  task automatic drain(input string tag);
    int i;
    for (i = 0; i < 6000 && (tx_q.size() > 0 || line_ticks > 0); i++) step();
    if (tx_q.size() > 0 || line_ticks > 0) check({tag, "_drain_timeout"}, 32'd1, 32'd0);
    repeat (2) step();
  endtask

  task automatic do_read();
    int i;
    req_read = 1'b1;
    for (i = 0; i < 20 && req_read; i++) step();
    @(posedge clk);
    #1;
    m_clear(1'b0);
  endtask

  initial begin
    logic [7:0] d;
    bit         stop;

    repeat (5) step();
    check_all("reset");
    rst = 1'b0;
    repeat (8) step();

    // Nominal frame and latency: stop sample 152 ticks (608 clk) after the start edge.
    rda_rise_cyc = -1;
    push_frame(8'hA5, 1'b1, 1'b0, 4);
    drain("a5");
    m_frame(8'hA5, 1'b1, 1'b0);
    check_all("a5");
    check("a5_latency", 32'(rda_rise_cyc - start_cyc), 32'd609);

    // Three-tick glitch is rejected, then a real frame follows.
    do_read();
    check_all("read_a5");
    tx_q.push_back('{1'b0, 3, 1'b0, 1'b0});
    tx_q.push_back('{1'b1, 40, 1'b0, 1'b0});
    drain("glitch");
    check_all("glitch");
    push_frame(8'h5A, 1'b1, 1'b0, 4);
    drain("5a");
    m_frame(8'h5A, 1'b1, 1'b0);
    check_all("5a");

    // Framing error, then read clears all flags.
    do_read();
    push_frame(8'h3C, 1'b0, 1'b0, 4);
    drain("3c");
    m_frame(8'h3C, 1'b0, 1'b0);
    check_all("3c_ferr");
    do_read();
    check_all("3c_read");

    // Back-to-back frames without a read give overrun.
    push_frame(8'h11, 1'b1, 1'b0, 0);
    push_frame(8'h22, 1'b1, 1'b0, 4);
    drain("ovr");
    m_frame(8'h11, 1'b1, 1'b0);
    m_frame(8'h22, 1'b1, 1'b0);
    check_all("ovr");

    // Read on the exact completion cycle of the second frame: completion wins.
    do_read();
    push_frame(8'h11, 1'b1, 1'b0, 0);
    push_frame(8'h22, 1'b1, 1'b1, 4);
    drain("rd_same");
    m_frame(8'h11, 1'b1, 1'b0);
    m_frame(8'h22, 1'b1, 1'b1);
    check_all("rd_same");

    // Reset during data bit 4 discards the frame; the next frame is clean.
    fork
      begin
        push_frame(8'hFF, 1'b1, 1'b0, 4);
        drain("ff");
      end
      begin
        repeat (350) step();
        rst = 1'b1;
        step();
        m_clear(1'b1);
        check_all("rst_mid");
        rst = 1'b0;
      end
    join
    check_all("after_ff");
    push_frame(8'h81, 1'b1, 1'b0, 4);
    drain("81");
    m_frame(8'h81, 1'b1, 1'b0);
    check_all("81");

    // Enable stall mid-frame: nothing completes while stalled, byte intact after.
    do_read();
    d = 8'($urandom_range(0, 255));
    fork
      begin
        push_frame(d, 1'b1, 1'b0, 4);
        drain("stall");
      end
      begin
        repeat (300) step();
        en_run = 1'b0;
        repeat (1000) step();
        check("stall_no_rda", 32'(rda), 32'd0);
        en_run = 1'b1;
      end
    join
    m_frame(d, 1'b1, 1'b0);
    check_all("stall");

    // Randomised frames, random stop bit, optional read beforehand.
    for (int k = 0; k < 6; k++) begin
      if ($urandom_range(0, 1) == 1) do_read();
      d    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 3) != 0);
      push_frame(d, stop, 1'b0, 1 + int'($urandom_range(0, 20)));
      drain("rand");
      m_frame(d, stop, 1'b0);
      check_all($sformatf("rand%0d", k));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
